phoenix_memory_responder: RTL

- Memory-side responder for the phoeniX core's load/store port.
- The core initiates a request; this block accepts it, waits a programmable latency, performs the byte/half/word access on an internal word array, and returns a response through a valid/ready handshake.
- Replaces the ideal zero-wait memory so the core's stall logic is exercised.
- The array is named Memory, so benches can preload it with $readmemh.

---
 rtl/phoenix_memory_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/phoenix_memory_responder.sv
// Memory-side responder for the phoeniX load/store port: accepts one request,
// waits LATENCY cycles, performs the byte/half/word access and holds the response.
module phoenix_memory_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    logic [1:0]  state;
    logic [3:0]  count;
    logic [31:0] cap_address;
    logic        cap_write;
    logic [1:0]  cap_size;
    logic        cap_sign;
    logic [31:0] cap_wdata;

    logic [31:0] Memory [0:(1<<DEPTH_LOG2)-1];

    logic [DEPTH_LOG2-1:0] word_index;
    logic [31:0]           rd_word;
    logic [31:0]           shifted;
    logic [31:0]           load_data;
    logic [31:0]           merged;
    logic [31:0]           wdata_rep;
    logic [3:0]            byte_en;
    logic                  access_error;
    logic                  access_edge;

    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESPOND);
    assign access_edge = (state == WAIT) && (count == 4'd0);
    assign word_index  = cap_address[DEPTH_LOG2+1:2];
    assign rd_word     = Memory[word_index];

    assign access_error = (cap_size == 2'b11)
                       || (cap_size == 2'b01 && cap_address[0])
                       || (cap_size == 2'b10 && cap_address[1:0] != 2'b00)
                       || ((cap_address >> (DEPTH_LOG2 + 2)) != 32'd0);

    // Alignment is guaranteed for error-free accesses, so a lane shift also
    // lands a half on bit 0.
    assign shifted = rd_word >> {cap_address[1:0], 3'b000};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_data = rd_word;
        case (cap_size)
            2'b00:   load_data = {{24{cap_sign & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{cap_sign & shifted[15]}}, shifted[15:0]};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = cap_wdata;
        case (cap_size)
            2'b00: begin
                byte_en   = 4'b0001 << cap_address[1:0];
                wdata_rep = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = cap_address[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cap_wdata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata_rep = cap_wdata;
            end
        endcase
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_address <= req_address;
                        cap_write   <= req_write;
                        cap_size    <= req_size;
                        cap_sign    <= req_sign;
                        cap_wdata   <= req_wdata;
                        count       <= 4'(LATENCY - 1);
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state     <= RESPOND;
                        rsp_error <= access_error;
                        rsp_rdata <= (access_error || cap_write) ? 32'd0 : load_data;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_rdata <= 32'd0;
                        rsp_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array is deliberately left out of reset; contents survive it.
    always_ff @(posedge CLK) begin
        if (!reset && access_edge && cap_write && !access_error)
            Memory[word_index] <= merged;
    end

endmodule
